// File: rtl/exe_stage.sv
// Execute stage of the 5-stage MIPS pipeline: single-cycle ALU plus an iterative
// 32-step shift-add multiplier / restoring divider, feeding a registered EXE/MEM boundary.
module exe_stage #(
  parameter logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [3:0]  exe_cmd,
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  input  logic [31:0] st_val_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        wb_en_in,
  input  logic [4:0]  dest_in,
  input  logic        mem_ready,
  output logic        busy,
  output logic        valid_out,
  output logic [31:0] alu_result,
  output logic [31:0] st_val,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic        wb_en,
  output logic [4:0]  dest
);

  localparam logic [3:0] CMD_MUL  = 4'b1100;
  localparam logic [3:0] CMD_DIVU = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_q;
  logic [31:0] r_acc;
  logic [31:0] r_rem;
  logic        r_is_div;
  logic [31:0] r_st_l;
  logic        r_mem_r_l;
  logic        r_mem_w_l;
  logic        r_wb_l;
  logic [4:0]  r_dest_l;

  logic        r_valid;
  logic [31:0] r_alu;
  logic [31:0] r_st;
  logic        r_mem_r;
  logic        r_mem_w;
  logic        r_wb;
  logic [4:0]  r_dest;

  logic        w_is_md;
  logic        w_start;
  logic        w_load;
  logic        w_n_valid;
  logic [31:0] w_n_alu;
  logic [31:0] w_n_st;
  logic        w_n_mem_r;
  logic        w_n_mem_w;
  logic        w_n_wb;
  logic [4:0]  w_n_dest;
  logic [32:0] w_rem_sh;
  logic [32:0] w_sub;
  logic [31:0] w_md_result;

  function automatic logic [31:0] alu_op(input logic [3:0] cmd,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] res;
    case (cmd)
      4'b0000: res = a + b;
      4'b0010: res = a - b;
      4'b0100: res = a & b;
      4'b0101: res = a | b;
      4'b0110: res = ~(a | b);
      4'b0111: res = a ^ b;
      4'b1000: res = a << b[4:0];
      4'b1001: res = $unsigned($signed(a) >>> b[4:0]);
      4'b1010: res = a >> b[4:0];
      4'b1011: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  assign w_is_md = (exe_cmd == CMD_MUL) || (exe_cmd == CMD_DIVU);

  // Restoring-divide step: borrow out of the 33-bit subtract means "does not fit".
  assign w_rem_sh = {r_rem, r_q[31]};
  assign w_sub    = w_rem_sh - {1'b0, r_b};

  assign w_md_result = r_is_div ? ((r_b == 32'd0) ? DIV0_RESULT : r_q) : r_acc;

  assign busy = !mem_ready
              | (r_state == S_MUL) | (r_state == S_DIV)
              | ((r_state == S_IDLE) & valid_in & w_is_md);

  assign valid_out  = r_valid;
  assign alu_result = r_alu;
  assign st_val     = r_st;
  assign mem_r_en   = r_mem_r;
  assign mem_w_en   = r_mem_w;
  assign wb_en      = r_wb;
  assign dest       = r_dest;

  // Next state and the value the EXE/MEM register takes at the coming edge.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_n_valid   = 1'b0;
    w_n_alu     = 32'd0;
    w_n_st      = 32'd0;
    w_n_mem_r   = 1'b0;
    w_n_mem_w   = 1'b0;
    w_n_wb      = 1'b0;
    w_n_dest    = 5'd0;
    case (r_state)
      S_IDLE: begin
        if (mem_ready) begin
          w_load = 1'b1;
          if (valid_in && w_is_md) begin
            w_start     = 1'b1;
            w_state_nxt = (exe_cmd == CMD_DIVU) ? S_DIV : S_MUL;
          end else if (valid_in) begin
            w_n_valid = 1'b1;
            w_n_alu   = alu_op(exe_cmd, val1, val2);
            w_n_st    = st_val_in;
            w_n_mem_r = mem_r_en_in;
            w_n_mem_w = mem_w_en_in;
            w_n_wb    = wb_en_in;
            w_n_dest  = dest_in;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_load = 1'b0;
        end
      end
      S_MUL, S_DIV: begin
        w_load = mem_ready;
        if (r_cnt == 5'd31) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_DONE: begin
        if (mem_ready) begin
          w_load      = 1'b1;
          w_n_valid   = 1'b1;
          w_n_alu     = w_md_result;
          w_n_st      = r_st_l;
          w_n_mem_r   = r_mem_r_l;
          w_n_mem_w   = r_mem_w_l;
          w_n_wb      = r_wb_l;
          w_n_dest    = r_dest_l;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Iterative MUL/DIVU datapath and latched passthroughs of the long instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 5'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_q       <= 32'd0;
      r_acc     <= 32'd0;
      r_rem     <= 32'd0;
      r_is_div  <= 1'b0;
      r_st_l    <= 32'd0;
      r_mem_r_l <= 1'b0;
      r_mem_w_l <= 1'b0;
      r_wb_l    <= 1'b0;
      r_dest_l  <= 5'd0;
    end else if (w_start) begin
      r_cnt     <= 5'd0;
      r_a       <= val1;
      r_b       <= val2;
      r_q       <= (exe_cmd == CMD_DIVU) ? val1 : val2;
      r_acc     <= 32'd0;
      r_rem     <= 32'd0;
      r_is_div  <= (exe_cmd == CMD_DIVU);
      r_st_l    <= st_val_in;
      r_mem_r_l <= mem_r_en_in;
      r_mem_w_l <= mem_w_en_in;
      r_wb_l    <= wb_en_in;
      r_dest_l  <= dest_in;
    end else if (r_state == S_MUL) begin
      // Only the low 32 product bits are kept, so the shifted multiplicand may truncate.
      r_acc <= r_q[0] ? (r_acc + r_a) : r_acc;
      r_a   <= {r_a[30:0], 1'b0};
      r_q   <= {1'b0, r_q[31:1]};
      r_cnt <= r_cnt + 5'd1;
    end else if (r_state == S_DIV) begin
      if (!w_sub[32]) begin
        r_rem <= w_sub[31:0];
        r_q   <= {r_q[30:0], 1'b1};
      end else begin
        r_rem <= w_rem_sh[31:0];
        r_q   <= {r_q[30:0], 1'b0};
      end
      r_cnt <= r_cnt + 5'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // EXE/MEM boundary register; frozen whenever MEM is not ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_alu   <= 32'd0;
      r_st    <= 32'd0;
      r_mem_r <= 1'b0;
      r_mem_w <= 1'b0;
      r_wb    <= 1'b0;
      r_dest  <= 5'd0;
    end else if (w_load) begin
      r_valid <= w_n_valid;
      r_alu   <= w_n_alu;
      r_st    <= w_n_st;
      r_mem_r <= w_n_mem_r;
      r_mem_w <= w_n_mem_w;
      r_wb    <= w_n_wb;
      r_dest  <= w_n_dest;
    end else begin
      r_valid <= r_valid;
    end
  end

endmodule
